interboard_tx_queue: RTL

- Parametrised inter-board transmitter. Accepts whole messages of NUM_FIELDS fields, each DATA_W bits wide, from GameControl through a valid/ready interface.
- Buffers up to FIFO_DEPTH messages, so GameControl no longer stalls on a busy link.
- Serialises each message field-by-field over the existing 4-phase Request/Ack inter-board link.
- Replaces the fixed 6-field, unbuffered sender. Adds a synchronised Ack input and an optional handshake timeout.

---
 rtl/interboard_tx_queue.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/interboard_tx_queue.sv
// interboard_tx_queue: buffered message transmitter for the 4-phase
// Request/Ack inter-board link. Whole messages of NUM_FIELDS fields are
// queued in a small FIFO and sent one field per handshake, field 0 first.
// Optional feature macro: INTERBOARD_TX_TIMEOUT_EN adds a handshake timeout
// that aborts a stuck message and pulses err_timeout.
module interboard_tx_queue #(
  parameter int DATA_W      = 6,
  parameter int NUM_FIELDS  = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           interboard_rst,
  input  logic                           msg_valid,
  input  logic [NUM_FIELDS*DATA_W-1:0]   msg_data,
  output logic                           msg_ready,
  input  logic                           Ack_in,
  output logic                           Request_out,
  output logic [DATA_W-1:0]              inter_data_out,
  output logic                           busy,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           err_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

`ifdef INTERBOARD_TX_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, SETUP, REQ, ACK_DN, RECOVER} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, REQ, ACK_DN} state_t;
`endif

  state_t                          state_q, state_d;
  logic [NUM_FIELDS*DATA_W-1:0]    mem [FIFO_DEPTH];
  logic [NUM_FIELDS*DATA_W-1:0]    msg_q;
  logic [DATA_W-1:0]               msg_field [NUM_FIELDS];
  logic [DATA_W-1:0]               head_field0;
  logic [PTR_W-1:0]                wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]                count_q;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [DATA_W-1:0]               data_q, data_d;
  logic                            req_q, err_q;
  logic                            push, pop, timeout_hit, ack_s;
  logic [SYNC_STAGES-1:0]          sync_q;

  // Split the in-flight message into addressable fields
  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
    assign msg_field[gi] = msg_q[gi*DATA_W +: DATA_W];
  end

  // Field 0 is taken straight from the FIFO head so it is on the bus during SETUP
  assign head_field0 = mem[rd_ptr_q][DATA_W-1:0];

  assign msg_ready      = (count_q != FULL_CNT);
  assign push           = msg_valid && msg_ready && !interboard_rst;
  assign pop            = (state_q == IDLE) && (count_q != '0) && !interboard_rst;
  assign ack_s          = sync_q[SYNC_STAGES-1];
  assign Request_out    = req_q;
  assign inter_data_out = data_q;
  assign fifo_count     = count_q;
  assign busy           = (state_q != IDLE) || (count_q != '0);
  assign err_timeout    = err_q;

`ifdef INTERBOARD_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] tmo_q;
  logic            in_hs;

  assign in_hs       = (state_q == REQ) || (state_q == ACK_DN);
  assign timeout_hit = in_hs && (tmo_q == TO_W'(TIMEOUT_CYC - 1));

  // Handshake watchdog: restarts on every state change, counts while waiting on the peer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (interboard_rst || (state_d != state_q)) begin
      tmo_q <= '0;
    end else if (in_hs) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Ack_in crosses from the other board; only ack_s is used by the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else if (interboard_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Ack_in};
    end
  end

  // Message storage; no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= msg_data;
    end
  end

  // Next-state logic of the field sender
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = SETUP;
          idx_d   = '0;
          data_d  = head_field0;
        end
      end
      SETUP:  state_d = REQ;
      REQ: begin
        if (ack_s) state_d = ACK_DN;
      end
      ACK_DN: begin
        if (!ack_s) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            data_d  = msg_field[idx_q + 1'b1];
            state_d = SETUP;
          end
        end
      end
`ifdef INTERBOARD_TX_TIMEOUT_EN
      RECOVER: begin
        if (!ack_s) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef INTERBOARD_TX_TIMEOUT_EN
    // An abort drops the rest of the message and waits for the peer to release Ack
    if (timeout_hit) state_d = RECOVER;
`endif
  end

  // State, registered outputs and FIFO bookkeeping; interboard_rst outranks everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      data_q   <= '0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      msg_q    <= '0;
    end else if (interboard_rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      data_q   <= '1;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      msg_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      req_q   <= (state_d == REQ);
      err_q   <= timeout_hit;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        msg_q    <= mem[rd_ptr_q];
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule
